q313_sat_accumulator: RTL and testbench
=======================================

Name: q313_sat_accumulator

Overview:
- Streaming saturating accumulator directly downstream of the Q3.13 saturating multiplier.
- Sums a burst of Q3.13 products, e.g. the stencil/neighbour weight × value terms of one CFD cell update.
- Emits one saturated Q3.13 sum per burst, with a flag if clamping occurred.
- Valid/ready handshake on both sides so it can sit between pipelined datapath stages.

Parameters:
- GUARD, 8, extra integer guard bits in the internal accumulator (ACC_W = 16 + GUARD).
- MAX_LEN, 16, maximum terms per burst; a burst auto-terminates at this count; legal range 1..2^GUARD.
- CNT_W, 5, width of the term counter and out_count; must hold MAX_LEN (clog2(MAX_LEN+1)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  16  signed Q3.13 product term.
- in_last  in  1  final term of the current burst.
- out_valid  out  1  burst result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  signed Q3.13 saturated sum.
- out_sat  out  1  sum was clamped to 0x7FFF or 0x8000.
- out_count  out  CNT_W  number of terms in the burst.

Behaviour:
- Reset (synchronous, wins over all other activity including mid-burst):
  - acc=0, cnt=0, out_valid=0, out_data=0x0000, out_sat=0, out_count=0.
  - Any partial burst is discarded.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - An input beat is accepted when in_valid & in_ready.
  - An output is taken when out_valid & out_ready.
- Accept, non-final beat:
  - acc <= acc + sign-extended in_data (ACC_W bits).
  - cnt <= cnt+1.
- Final beat, when in_last=1 or cnt+1 == MAX_LEN:
  - sum = acc + sext(in_data).
  - Next cycle: out_valid=1, out_data = sat(sum), out_sat set per saturation, out_count = cnt+1.
  - Same edge: acc <= 0, cnt <= 0.
  - Latency: result visible the cycle after the final beat is accepted.
- Saturation:
  - sum > 32767 -> 0x7FFF, sat=1.
  - sum < -32768 -> 0x8000, sat=1.
  - Otherwise sum[15:0], sat=0.
  - The accumulator itself never wraps, because MAX_LEN <= 2^GUARD.
- States:
  - ACCUM (out_valid=0): accepting beats.
  - HOLD (out_valid=1): result held stable until taken.
  - HOLD with out_ready=0: out_data/out_sat/out_count frozen, in_ready=0, acc untouched.
- Simultaneous events:
  - Output taken and new beat accepted in the same cycle: the beat starts a fresh burst (acc starts from 0).
  - If that beat is also final: the new result loads and out_valid stays 1 (back-to-back, one result per cycle possible).
  - Output taken and no final beat: out_valid -> 0 next cycle.
- Data and flag handling:
  - in_data/in_last are ignored when not accepted.
  - in_last with cnt+1 == MAX_LEN produces a single result, not two.
  - A single-beat burst (in_last on the first beat) is legal; out_count=1.

Test Plan:
- Burst 0x2000, 0x2000, 0x2000(last), out_ready=1 -> one cycle after last: out_data=0x6000, out_sat=0, out_count=3.
- Burst 5× 0x7000, last on 5th -> out_data=0x7FFF, out_sat=1, out_count=5; next burst 0x1000(last) -> 0x1000, out_sat=0 (no residue).
- Burst 0x8000, 0xE000(last) -> out_data=0x8000, out_sat=1; mixed 0x4000, 0xC000(last) -> 0x0000, out_sat=0.
- MAX_LEN=16, 17 beats of 0x0100, no in_last -> first result 0x1000, count 16 after beat 16; beat 17 begins a new burst.
- out_ready=0 for 4 cycles while result pending -> in_ready=0, outputs stable. Then out_ready=1 with a single-beat final 0x0800 offered -> old result taken, new result 0x0800 valid next cycle, out_valid never drops.
- rst asserted after 2 of 4 beats (0x1000 each), then beats 0x0200, 0x0200(last) -> out_data=0x0400, out_count=2.

Source files
------------

// File: rtl/q313_sat_accumulator_if.sv
// Handshake bundle for the Q3.13 saturating accumulator.
// The input side carries product terms. The output side carries one saturated sum per burst.
interface q313_sat_accumulator_if #(
   parameter int CNT_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_data;
   logic             out_sat;
   logic [CNT_W-1:0] out_count;

   // The accumulator side.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_sat, out_count
   );

   // The producer/consumer side that surrounds the accumulator.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_sat, out_count
   );
endinterface

// File: rtl/q313_sat_accumulator.sv
// Streaming saturating accumulator for Q3.13 product terms.
// It sums one burst of terms in a guard-extended accumulator. It then emits the sum clamped to
// Q3.13, a clamp flag and the term count. A result is held until the downstream stage takes it.
module q313_sat_accumulator #(
   parameter int GUARD   = 8,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   q313_sat_accumulator_if.slave bus
);
   localparam int ACC_W = 16 + GUARD;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

   // ACCUM: collecting terms. HOLD: a result is presented on the output.
   typedef enum logic {ACCUM, HOLD} state_t;

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt;
   logic [15:0]             out_data_q;
   logic                    out_sat_q;
   logic [CNT_W-1:0]        out_count_q;

   logic                    out_valid;
   logic                    accept;
   logic                    take;
   logic                    is_final;
   logic [CNT_W-1:0]        cnt_inc;
   logic signed [ACC_W-1:0] sum;
   logic [15:0]             sat_data;
   logic                    sat_flag;

   assign out_valid     = (state == HOLD);
   assign bus.in_ready  = !out_valid || bus.out_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.out_count = out_count_q;

   assign accept   = bus.in_valid && bus.in_ready;
   assign take     = out_valid && bus.out_ready;
   assign cnt_inc  = cnt + CNT_W'(1);
   assign is_final = bus.in_last || (cnt_inc == CNT_W'(MAX_LEN));

   // acc is always zero while a result is held. A beat accepted in the same cycle as a take
   // therefore starts a fresh burst without any extra clearing logic.
   assign sum = acc + {{GUARD{bus.in_data[15]}}, bus.in_data};

   // Clamp the wide running sum to the Q3.13 range and flag any clamping.
   always_comb begin
      // NOTE: give every output a default first so no path leaves it unassigned; that is what infers a latch.
      sat_data = sum[15:0];
      sat_flag = 1'b0;
      if (sum > SAT_MAX) begin
         sat_data = 16'h7FFF;
         sat_flag = 1'b1;
      end else if (sum < SAT_MIN) begin
         sat_data = 16'h8000;
         sat_flag = 1'b1;
      end
   end

   // Burst control: accumulate terms, load the result on the final term, release it on a take.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state       <= ACCUM;
         acc         <= '0;
         cnt         <= '0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_count_q <= '0;
      end else if (accept) begin
         if (is_final) begin
            acc         <= '0;
            cnt         <= '0;
            out_data_q  <= sat_data;
            out_sat_q   <= sat_flag;
            out_count_q <= cnt_inc;
            state       <= HOLD;
         end else begin
            acc <= sum;
            cnt <= cnt_inc;
            if (take) begin
               state <= ACCUM;
            end
         end
      end else if (take) begin
         state <= ACCUM;
      end
   end
endmodule

// File: tb/tb_q313_sat_accumulator.sv
// Self-checking bench for q313_sat_accumulator.
// The bench runs directed vectors, hand-written corner sequences and random traffic.
// Each cycle is also checked against a burst-level model that keeps the pending terms in a queue.
module tb_q313_sat_accumulator;
   localparam int MAX_LEN = 16;
   localparam int CNT_W   = 5;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   q313_sat_accumulator_if #(.CNT_W(CNT_W)) bus ();

   q313_sat_accumulator #(.GUARD(8), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Burst-level reference model.
   int          terms[$];
   logic        m_valid;
   logic [15:0] m_data;
   logic        m_sat;
   int          m_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      terms.delete();
      m_valid = 1'b0;
      m_data  = 16'h0000;
      m_sat   = 1'b0;
      m_count = 0;
   endtask

   // Sum the queued terms with plain integer arithmetic, then clamp the total to Q3.13.
   task automatic model_finish_burst();
      int s = 0;
      foreach (terms[i]) s += terms[i];
      if (s > 32767) begin
         m_data = 16'h7FFF;
         m_sat  = 1'b1;
      end else if (s < -32768) begin
         m_data = 16'h8000;
         m_sat  = 1'b1;
      end else begin
         m_data = 16'(s);
         m_sat  = 1'b0;
      end
      m_count = terms.size();
      m_valid = 1'b1;
      terms.delete();
   endtask

   // Drive one cycle of inputs and check in_ready before the edge.
   // At the edge, update the model. Check the outputs 1 ns later.
   task automatic cycle(input logic rs, input logic v, input logic [15:0] d,
                        input logic l, input logic r);
      logic exp_ready;
      logic accepted;
      rst          = rs;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_last  = l;
      bus.out_ready = r;
      #1;
      exp_ready = !m_valid || r;
      check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      accepted = v && exp_ready;
      @(posedge clk);
      if (rs) begin
         model_reset();
      end else begin
         if (accepted) begin
            terms.push_back(int'($signed(d)));
            if (l || terms.size() == MAX_LEN) model_finish_burst();
            else if (m_valid && r) m_valid = 1'b0;
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
      end
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("out_data",  32'(bus.out_data),  32'(m_data));
      check("out_sat",   32'(bus.out_sat),   32'(m_sat));
      check("out_count", 32'(bus.out_count), 32'(m_count));
   endtask

   typedef struct {
      logic        rs;
      logic        v;
      logic [15:0] d;
      logic        l;
      logic        r;
      logic        e_valid;
      logic [15:0] e_data;
      logic        e_sat;
      logic [4:0]  e_count;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rs, input logic v, input logic [15:0] d,
                               input logic l, input logic r, input logic ev,
                               input logic [15:0] ed, input logic es, input logic [4:0] ec);
      vec_t x;
      x.rs = rs; x.v = v; x.d = d; x.l = l; x.r = r;
      x.e_valid = ev; x.e_data = ed; x.e_sat = es; x.e_count = ec;
      return x;
   endfunction

   initial begin
      logic        prev_data_ok;
      logic [15:0] held_data;
      logic        ov_seen_low;

      model_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state.
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_out_data",  32'(bus.out_data),  32'd0);
      check("reset_out_count", 32'(bus.out_count), 32'd0);

      // Directed vectors. Each line gives the inputs, then the outputs expected after the edge.
      // 0x2000 x3 -> 0x6000
      vecs.push_back(mk(0, 1, 16'h2000, 0, 1,  0, 16'h0000, 0, 5'd0));
      vecs.push_back(mk(0, 1, 16'h2000, 0, 1,  0, 16'h0000, 0, 5'd0));
      vecs.push_back(mk(0, 1, 16'h2000, 1, 1,  1, 16'h6000, 0, 5'd3));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h6000, 0, 5'd3));
      // 5 x 0x7000 -> positive clamp
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 1, 16'h7000, 0, 1,  0, 16'h6000, 0, 5'd3));
      vecs.push_back(mk(0, 1, 16'h7000, 1, 1,  1, 16'h7FFF, 1, 5'd5));
      // Single beat 0x1000, taken together with the old result: no residue
      vecs.push_back(mk(0, 1, 16'h1000, 1, 1,  1, 16'h1000, 0, 5'd1));
      // 0x8000 + 0xE000 -> negative clamp
      vecs.push_back(mk(0, 1, 16'h8000, 0, 1,  0, 16'h1000, 0, 5'd1));
      vecs.push_back(mk(0, 1, 16'hE000, 1, 1,  1, 16'h8000, 1, 5'd2));
      // 0x4000 + 0xC000 -> 0
      vecs.push_back(mk(0, 1, 16'h4000, 0, 1,  0, 16'h8000, 1, 5'd2));
      vecs.push_back(mk(0, 1, 16'hC000, 1, 1,  1, 16'h0000, 0, 5'd2));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 5'd2));
      // Reset mid-burst discards the partial sum
      vecs.push_back(mk(0, 1, 16'h1000, 0, 1,  0, 16'h0000, 0, 5'd2));
      vecs.push_back(mk(0, 1, 16'h1000, 0, 1,  0, 16'h0000, 0, 5'd2));
      vecs.push_back(mk(1, 1, 16'h1000, 0, 1,  0, 16'h0000, 0, 5'd0));
      vecs.push_back(mk(0, 1, 16'h0200, 0, 1,  0, 16'h0000, 0, 5'd0));
      vecs.push_back(mk(0, 1, 16'h0200, 1, 1,  1, 16'h0400, 0, 5'd2));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0400, 0, 5'd2));

      foreach (vecs[i]) begin
         cycle(vecs[i].rs, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
         check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d_data", i),  32'(bus.out_data),  32'(vecs[i].e_data));
         check($sformatf("vec%0d_sat", i),   32'(bus.out_sat),   32'(vecs[i].e_sat));
         check($sformatf("vec%0d_count", i), 32'(bus.out_count), 32'(vecs[i].e_count));
      end

      // 17 beats of 0x0100 with no in_last. The burst auto-terminates after beat 16.
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1);
      check("maxlen_valid", 32'(bus.out_valid), 32'd1);
      check("maxlen_data",  32'(bus.out_data),  32'h1000);
      check("maxlen_count", 32'(bus.out_count), 32'd16);
      cycle(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1);
      check("beat17_valid", 32'(bus.out_valid), 32'd0);
      cycle(1'b0, 1'b1, 16'h0100, 1'b1, 1'b1);
      check("beat17_data",  32'(bus.out_data),  32'h0200);
      check("beat17_count", 32'(bus.out_count), 32'd2);

      // in_last on beat MAX_LEN yields exactly one result.
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 16'h0001, 1'b1, 1'b1);
      check("last_at_max_count", 32'(bus.out_count), 32'd16);
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      check("last_at_max_single", 32'(bus.out_valid), 32'd0);

      // Backpressure: hold the result for 4 cycles while a beat is offered.
      // Then take the result and accept a single-beat burst in the same cycle.
      cycle(1'b0, 1'b1, 16'h3000, 1'b1, 1'b0);
      held_data = bus.out_data;
      prev_data_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 16'h0123, 1'b1, 1'b0);
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         check("stall_valid",    32'(bus.out_valid), 32'd1);
         check("stall_data",     32'(bus.out_data),  32'(held_data));
         if (bus.out_data !== 16'h3000) prev_data_ok = 1'b0;
      end
      check("stall_data_value", 32'(prev_data_ok), 32'd1);
      ov_seen_low = 1'b0;
      cycle(1'b0, 1'b1, 16'h0800, 1'b1, 1'b1);
      if (!bus.out_valid) ov_seen_low = 1'b1;
      check("b2b_data",  32'(bus.out_data),  32'h0800);
      check("b2b_count", 32'(bus.out_count), 32'd1);
      check("b2b_never_dropped", 32'(ov_seen_low), 32'd0);
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

      // Random traffic checked against the model.
      for (int i = 0; i < 3000; i++) begin
         logic        rs_r;
         logic        v_r;
         logic        l_r;
         logic        r_r;
         logic [15:0] d_r;
         rs_r = ($urandom_range(0, 199) == 0);
         v_r  = ($urandom_range(0, 3) != 0);
         l_r  = ($urandom_range(0, 4) == 0);
         r_r  = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 2))
            0:       d_r = 16'($urandom);
            1:       d_r = 16'($urandom_range(0, 16'h0FFF));
            default: d_r = 16'(-int'($urandom_range(0, 16'h0FFF)));
         endcase
         cycle(rs_r, v_r, d_r, l_r, r_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
